// File: rtl/obi_arb_pkg.sv
// Shared types and defaults for the two-master OBI memory arbiter.
package obi_arb_pkg;

   localparam int unsigned DEFAULT_MAX_OUTSTANDING = 2;

   typedef enum logic {
      OWNER_INSTR = 1'b0,
      OWNER_DATA  = 1'b1
   } owner_e;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

endpackage

// File: rtl/obi_arb_owner_fifo.sv
// In-order FIFO of response owners, one entry per granted-but-unanswered request.
module obi_arb_owner_fifo
   import obi_arb_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_MAX_OUTSTANDING
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       push,
   input  owner_e     push_owner,
   input  logic       pop,
   output owner_e     head,
   output logic [1:0] count,
   output logic       full,
   output logic       empty
);

   // Storage sized for the largest legal depth so 2-bit pointers index it directly.
   owner_e     mem_q [4];
   logic [1:0] wptr_q, rptr_q, count_q;
   logic       do_push, do_pop;

   function automatic logic [1:0] ptr_next(input logic [1:0] p);
      return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   assign full    = (count_q == 2'(DEPTH));
   assign empty   = (count_q == 2'd0);
   assign count   = count_q;
   assign head    = mem_q[rptr_q];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr_q  <= 2'd0;
         rptr_q  <= 2'd0;
         count_q <= 2'd0;
         for (int i = 0; i < 4; i++) mem_q[i] <= OWNER_INSTR;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= push_owner;
            wptr_q        <= ptr_next(wptr_q);
         end
         if (do_pop) rptr_q <= ptr_next(rptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Round-robin arbiter sharing one OBI memory port between instruction and data masters.
module obi_mem_arbiter
   import obi_arb_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   input  logic [31:0] instr_addr_i,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [1:0]  outstanding_o,
   output logic        protocol_err_o
);

   arb_state_e state_q, state_d;
   owner_e     sel, sel_q, rr_q, fifo_head;
   logic       can_issue, hs, routed;
   logic       fifo_full, fifo_empty;
   logic [1:0] fifo_count;

   // Issue capacity is judged on the current count; a same-cycle response does not free a slot.
   assign can_issue = ~reset & ~fifo_full;

   always_comb begin
      state_d   = state_q;
      sel       = sel_q;
      mem_req_o = 1'b0;
      case (state_q)
         ARB: begin
            if (can_issue && (instr_req_i || data_req_i)) begin
               mem_req_o = 1'b1;
               if (instr_req_i && data_req_i)
                  sel = (rr_q == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
               else
                  sel = data_req_i ? OWNER_DATA : OWNER_INSTR;
               if (!mem_gnt_i) state_d = LOCK;
            end
         end
         LOCK: begin
            if (can_issue) begin
               mem_req_o = 1'b1;
               if (mem_gnt_i) state_d = ARB;
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_comb begin
      mem_addr_o  = 32'd0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_wdata_o = 32'd0;
      if (mem_req_o) begin
         if (sel == OWNER_DATA) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
         end else begin
            mem_addr_o  = instr_addr_i;
            mem_be_o    = 4'hF;
         end
      end
   end

   assign hs          = mem_req_o & mem_gnt_i;
   assign instr_gnt_o = hs & (sel == OWNER_INSTR);
   assign data_gnt_o  = hs & (sel == OWNER_DATA);

   assign routed         = mem_rvalid_i & ~fifo_empty & ~reset;
   assign instr_rvalid_o = routed & (fifo_head == OWNER_INSTR);
   assign data_rvalid_o  = routed & (fifo_head == OWNER_DATA);
   assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'd0;
   assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : 32'd0;
   assign outstanding_o  = fifo_count;

   // rr_q records the last granted owner; reset to instr so data wins the first tie.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ARB;
         sel_q          <= OWNER_INSTR;
         rr_q           <= OWNER_INSTR;
         protocol_err_o <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel;
         if (hs) rr_q <= sel;
         if (mem_rvalid_i && fifo_empty) protocol_err_o <= 1'b1;
      end
   end

   obi_arb_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_owner_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (hs),
      .push_owner (sel),
      .pop        (routed),
      .head       (fifo_head),
      .count      (fifo_count),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed bench for obi_mem_arbiter with the default depth of two.
module tb_obi_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
   logic [31:0] instr_addr_i, instr_rdata_o;
   logic        data_req_i, data_gnt_o, data_we_i, data_rvalid_o;
   logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
   logic [3:0]  data_be_i;
   logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [3:0]  mem_be_o;
   logic [1:0]  outstanding_o;
   logic        protocol_err_o;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   obi_mem_arbiter dut (
      .clock(clock), .reset(reset),
      .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
      .data_wdata_i(data_wdata_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      chk(tag, {31'd0, obs}, {31'd0, exp});
   endtask

   task automatic chk_cnt(input string tag, input logic [1:0] exp);
      chk(tag, {30'd0, outstanding_o}, {30'd0, exp});
   endtask

   task automatic grants(input string tag, input logic ei, input logic ed);
      chk1({tag, "_igrant"}, instr_gnt_o, ei);
      chk1({tag, "_dgrant"}, data_gnt_o, ed);
   endtask

   task automatic rsp(input string tag, input logic ei, input logic ed,
                      input logic [31:0] ri, input logic [31:0] rd);
      chk1({tag, "_irv"}, instr_rvalid_o, ei);
      chk1({tag, "_drv"}, data_rvalid_o, ed);
      chk({tag, "_irdata"}, instr_rdata_o, ri);
      chk({tag, "_drdata"}, data_rdata_o, rd);
   endtask

   task automatic next();
      @(negedge clock);
   endtask

   task automatic drv_i(input logic req, input logic [31:0] addr);
      instr_req_i = req; instr_addr_i = addr;
   endtask

   task automatic drv_d(input logic req, input logic [31:0] addr, input logic we,
                        input logic [3:0] be, input logic [31:0] wdata);
      data_req_i = req; data_addr_i = addr; data_we_i = we; data_be_i = be; data_wdata_i = wdata;
   endtask

   task automatic drv_m(input logic gnt, input logic rv, input logic [31:0] rdata);
      mem_gnt_i = gnt; mem_rvalid_i = rv; mem_rdata_i = rdata;
   endtask

   initial begin
      reset = 1'b1;
      drv_i(1'b1, 32'h1A00_0000);
      drv_d(1'b1, 32'h0000_0200, 1'b1, 4'h5, 32'hCAFE_F00D);
      drv_m(1'b1, 1'b1, 32'h1234_5678);
      next(); next(); #1;
      // Outputs under reset, with every input active
      chk1("rst_memreq", mem_req_o, 1'b0);
      grants("rst", 1'b0, 1'b0);
      rsp("rst", 1'b0, 1'b0, 32'd0, 32'd0);
      chk("rst_addr", mem_addr_o, 32'd0);
      chk("rst_be", {28'd0, mem_be_o}, 32'd0);
      chk("rst_wdata", mem_wdata_o, 32'd0);
      chk_cnt("rst_cnt", 2'd0);
      chk1("rst_err", protocol_err_o, 1'b0);

      // Both requesting, grant always high: D then I, then full
      next(); reset = 1'b0;
      drv_d(1'b1, 32'h0000_0200, 1'b0, 4'hF, 32'd0);
      drv_m(1'b1, 1'b0, 32'd0); #1;
      chk1("rr0_err", protocol_err_o, 1'b0);
      chk1("rr0_memreq", mem_req_o, 1'b1);
      grants("rr0", 1'b0, 1'b1);
      chk("rr0_addr", mem_addr_o, 32'h0000_0200);
      next(); #1;
      chk_cnt("rr1_cnt", 2'd1);
      grants("rr1", 1'b1, 1'b0);
      chk("rr1_addr", mem_addr_o, 32'h1A00_0000);
      next(); #1;
      chk_cnt("rr2_cnt", 2'd2);
      chk1("rr2_memreq", mem_req_o, 1'b0);
      grants("rr2", 1'b0, 1'b0);
      // Full with response in the same cycle: still no request
      next(); drv_m(1'b1, 1'b1, 32'h55); #1;
      chk1("full_rv_memreq", mem_req_o, 1'b0);
      rsp("full_rv", 1'b0, 1'b1, 32'd0, 32'h55);
      // Count 1, grant and response together
      next(); drv_m(1'b1, 1'b1, 32'h66); #1;
      chk_cnt("same_cnt_before", 2'd1);
      grants("same", 1'b0, 1'b1);
      rsp("same", 1'b1, 1'b0, 32'h66, 32'd0);
      next(); drv_i(1'b0, 32'd0); drv_d(1'b0, 32'd0, 1'b0, 4'h0, 32'd0);
      drv_m(1'b0, 1'b1, 32'h77); #1;
      chk_cnt("same_cnt_after", 2'd1);
      rsp("drain", 1'b0, 1'b1, 32'd0, 32'h77);
      next(); drv_m(1'b0, 1'b0, 32'd0); #1;
      chk_cnt("drain_cnt", 2'd0);

      // Instr locked while grant withheld; data arrives and must wait
      drv_i(1'b1, 32'h1A00_0080); #1;
      chk1("lk0_memreq", mem_req_o, 1'b1);
      chk("lk0_addr", mem_addr_o, 32'h1A00_0080);
      grants("lk0", 1'b0, 1'b0);
      next(); drv_d(1'b1, 32'h0000_0100, 1'b0, 4'hF, 32'd0); #1;
      chk("lk1_addr", mem_addr_o, 32'h1A00_0080);
      grants("lk1", 1'b0, 1'b0);
      next(); #1;
      chk("lk2_addr", mem_addr_o, 32'h1A00_0080);
      next(); mem_gnt_i = 1'b1; #1;
      chk("lk3_addr", mem_addr_o, 32'h1A00_0080);
      grants("lk3", 1'b1, 1'b0);
      next(); drv_i(1'b0, 32'd0); #1;
      grants("lk4", 1'b0, 1'b1);
      chk("lk4_addr", mem_addr_o, 32'h0000_0100);
      next(); drv_d(1'b0, 32'd0, 1'b0, 4'h0, 32'd0); drv_m(1'b0, 1'b1, 32'hA1); #1;
      chk_cnt("lk_cnt", 2'd2);
      rsp("lk_r0", 1'b1, 1'b0, 32'hA1, 32'd0);
      next(); mem_rdata_i = 32'hA2; #1;
      rsp("lk_r1", 1'b0, 1'b1, 32'd0, 32'hA2);

      // Data write then instr fetch; responses return in issue order
      next(); drv_m(1'b1, 1'b0, 32'd0);
      drv_d(1'b1, 32'h0000_0100, 1'b1, 4'b0011, 32'hDEAD_BEEF); #1;
      chk_cnt("wr_cnt0", 2'd0);
      grants("wr", 1'b0, 1'b1);
      chk1("wr_we", mem_we_o, 1'b1);
      chk("wr_be", {28'd0, mem_be_o}, 32'h3);
      chk("wr_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      next(); drv_d(1'b0, 32'd0, 1'b0, 4'h0, 32'd0); drv_i(1'b1, 32'h1A00_0100); #1;
      grants("if", 1'b1, 1'b0);
      chk1("if_we", mem_we_o, 1'b0);
      chk("if_be", {28'd0, mem_be_o}, 32'hF);
      chk("if_wdata", mem_wdata_o, 32'd0);
      next(); drv_i(1'b0, 32'd0); drv_m(1'b0, 1'b1, 32'h11); #1;
      rsp("ord0", 1'b0, 1'b1, 32'd0, 32'h11);
      next(); mem_rdata_i = 32'h22; #1;
      rsp("ord1", 1'b1, 1'b0, 32'h22, 32'd0);

      // Stray response with nothing outstanding
      next(); mem_rdata_i = 32'h99; #1;
      chk_cnt("stray_cnt", 2'd0);
      rsp("stray", 1'b0, 1'b0, 32'd0, 32'd0);
      chk1("stray_err_pre", protocol_err_o, 1'b0);
      next(); drv_m(1'b0, 1'b0, 32'd0); #1;
      chk1("stray_err", protocol_err_o, 1'b1);
      next(); next(); #1;
      chk1("stray_err_hold", protocol_err_o, 1'b1);
      chk_cnt("stray_cnt_after", 2'd0);

      // Two outstanding, then reset wipes ownership
      mem_gnt_i = 1'b1; drv_d(1'b1, 32'h0000_0300, 1'b0, 4'hF, 32'd0); #1;
      grants("pre_d", 1'b0, 1'b1);
      next(); drv_d(1'b0, 32'd0, 1'b0, 4'h0, 32'd0); drv_i(1'b1, 32'h1A00_0200); #1;
      grants("pre_i", 1'b1, 1'b0);
      next(); drv_i(1'b0, 32'd0); #1;
      chk_cnt("pre_cnt", 2'd2);
      reset = 1'b1; drv_i(1'b1, 32'h1A00_0300); #1;
      chk1("mid_rst_memreq", mem_req_o, 1'b0);
      grants("mid_rst", 1'b0, 1'b0);
      next(); reset = 1'b0; drv_i(1'b0, 32'd0); #1;
      chk_cnt("post_rst_cnt", 2'd0);
      chk1("post_rst_memreq", mem_req_o, 1'b0);
      chk1("post_rst_err", protocol_err_o, 1'b0);
      drv_m(1'b0, 1'b1, 32'hBB); #1;
      rsp("stale", 1'b0, 1'b0, 32'd0, 32'd0);
      next(); drv_m(1'b0, 1'b0, 32'd0); #1;
      chk1("stale_err", protocol_err_o, 1'b1);
      chk_cnt("stale_cnt", 2'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
